// File: rtl/qu_common.sv
// Shared types and helpers for the Qu core execute units.
// The M-extension funct3 encodings and the multi-cycle unit's state set live here.
package qu_common;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  function automatic logic is_signed_opd1(input md_op_t op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: is_signed_opd1 = 1'b1;
      default:                            is_signed_opd1 = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_opd2(input md_op_t op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: is_signed_opd2 = 1'b1;
      default:                 is_signed_opd2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The first step is taken on the start edge, so the result is ready W cycles after start.
module md_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_r, dq_r, dvs_r;
  logic [CW-1:0] cnt_r;
  logic          active_r;

  logic [W-1:0]  src_rem_s, src_dq_s, src_dvs_s;
  logic [W:0]    shifted_s;
  logic          fits_s;
  logic [W-1:0]  step_rem_s, step_dq_s;

  // One restoring step, sourced from the fresh operands on start.
  always_comb begin
    src_rem_s = rem_r;
    src_dq_s  = dq_r;
    src_dvs_s = dvs_r;
    if (start) begin
      src_rem_s = {W{1'b0}};
      src_dq_s  = dividend;
      src_dvs_s = divisor;
    end else begin
      src_rem_s = rem_r;
      src_dq_s  = dq_r;
      src_dvs_s = dvs_r;
    end
    shifted_s = {src_rem_s, src_dq_s[W-1]};
    fits_s    = (shifted_s >= {1'b0, src_dvs_s});
    // When the divisor fits, the difference is below the divisor and so fits in W bits.
    step_rem_s = fits_s ? (shifted_s[W-1:0] - src_dvs_s) : shifted_s[W-1:0];
    step_dq_s  = {src_dq_s[W-2:0], fits_s};
  end

  // Partial remainder, quotient shift register and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r    <= {W{1'b0}};
      dq_r     <= {W{1'b0}};
      dvs_r    <= {W{1'b0}};
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (abort) begin
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (start) begin
      rem_r    <= step_rem_s;
      dq_r     <= step_dq_s;
      dvs_r    <= divisor;
      cnt_r    <= CW'(W - 1);
      active_r <= 1'b1;
    end else if (active_r && (cnt_r != {CW{1'b0}})) begin
      rem_r <= step_rem_s;
      dq_r  <= step_dq_s;
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign done      = active_r && (cnt_r == {CW{1'b0}});
  assign quotient  = dq_r;
  assign remainder = rem_r;

endmodule

// File: rtl/execute_md.sv
// Multi-cycle RV32M execute unit: iterative multiplier inline, restoring divider in md_div_core.
// One op in flight; the result is held on out_value/out_tag until the CDB arbiter takes it.
module execute_md
  import qu_common::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_BITS  = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_opd1,
  input  logic [XLEN-1:0]      in_opd2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_value,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int MCW       = $clog2(MUL_STEPS) + 1;
  localparam int PW        = 2 * XLEN;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [PW-1:0]   ONE_P  = {{(PW-1){1'b0}}, 1'b1};

  md_state_t state_r, state_next_s;
  md_op_t    op_r, op_in_s;
  logic [TAG_WIDTH-1:0] tag_r;
  logic                 neg1_r, neg2_r;
  logic [PW-1:0]        mcand_r, acc_r;
  logic [XLEN-1:0]      mplier_r;
  logic [MCW-1:0]       mul_cnt_r;
  logic [XLEN-1:0]      out_value_r;
  logic [TAG_WIDTH-1:0] out_tag_r;
  logic                 out_valid_r, in_ready_r, busy_r;

  logic            neg1_in_s, neg2_in_s, is_div_in_s, div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0] mag1_s, mag2_s, special_val_s;
  logic            accept_s, div_start_s, div_done_s;
  logic [XLEN-1:0] div_quo_s, div_rem_s, quo_s, rem_s, div_res_s, mul_res_s;
  logic [PW-1:0]   partial_s, acc_next_s, prod_s;
  logic            load_result_s;
  logic [XLEN-1:0] result_s;
  logic [TAG_WIDTH-1:0] result_tag_s;

  // Operand decode: magnitudes, sign flags and the divide special cases.
  always_comb begin
    op_in_s     = md_op_t'(in_funct3);
    neg1_in_s   = is_signed_opd1(op_in_s) && in_opd1[XLEN-1];
    neg2_in_s   = is_signed_opd2(op_in_s) && in_opd2[XLEN-1];
    // The most negative value's magnitude is exact as an unsigned XLEN-bit number.
    mag1_s      = neg1_in_s ? (~in_opd1 + ONE_X) : in_opd1;
    mag2_s      = neg2_in_s ? (~in_opd2 + ONE_X) : in_opd2;
    is_div_in_s = in_funct3[2];
    div_zero_s  = (in_opd2 == ZERO_X);
    div_ovf_s   = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                  (in_opd1 == MIN_X) && (in_opd2 == ONES_X);
    special_s   = is_div_in_s && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_val_s = in_funct3[1] ? in_opd1 : ONES_X;
    end else begin
      special_val_s = in_funct3[1] ? ZERO_X : in_opd1;
    end
  end

  assign accept_s    = in_valid && in_ready_r && !flush;
  assign div_start_s = accept_s && is_div_in_s && !special_s;

  md_div_core #(.W(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (div_start_s),
    .dividend  (mag1_s),
    .divisor   (mag2_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Multiply step and sign-corrected final results for both paths.
  always_comb begin
    partial_s  = mcand_r * {{(PW-MUL_BITS){1'b0}}, mplier_r[MUL_BITS-1:0]};
    acc_next_s = acc_r + partial_s;
    prod_s     = (neg1_r ^ neg2_r) ? (~acc_next_s + ONE_P) : acc_next_s;
    mul_res_s  = (op_r == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    quo_s      = (neg1_r ^ neg2_r) ? (~div_quo_s + ONE_X) : div_quo_s;
    rem_s      = neg1_r ? (~div_rem_s + ONE_X) : div_rem_s;
    div_res_s  = ((op_r == OP_REM) || (op_r == OP_REMU)) ? rem_s : quo_s;
  end

  // Next-state logic; flush overrides every transition and drops any result.
  always_comb begin
    state_next_s  = state_r;
    load_result_s = 1'b0;
    result_s      = ZERO_X;
    result_tag_s  = tag_r;
    case (state_r)
      MD_IDLE: begin
        if (accept_s && !is_div_in_s) begin
          state_next_s = MD_MUL;
        end else if (accept_s && special_s) begin
          state_next_s  = MD_DONE;
          load_result_s = 1'b1;
          result_s      = special_val_s;
          result_tag_s  = in_tag;
        end else if (accept_s) begin
          state_next_s = MD_DIV;
        end else begin
          state_next_s = MD_IDLE;
        end
      end
      MD_MUL: begin
        if (mul_cnt_r == MCW'(1)) begin
          state_next_s  = MD_DONE;
          load_result_s = 1'b1;
          result_s      = mul_res_s;
        end else begin
          state_next_s = MD_MUL;
        end
      end
      MD_DIV: begin
        if (div_done_s) begin
          state_next_s  = MD_DONE;
          load_result_s = 1'b1;
          result_s      = div_res_s;
        end else begin
          state_next_s = MD_DIV;
        end
      end
      MD_DONE: begin
        if (out_ready) begin
          state_next_s = MD_IDLE;
        end else begin
          state_next_s = MD_DONE;
        end
      end
      default: state_next_s = MD_IDLE;
    endcase
    if (flush) begin
      state_next_s  = MD_IDLE;
      load_result_s = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State register and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= MD_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_value_r <= ZERO_X;
      out_tag_r   <= {TAG_WIDTH{1'b0}};
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == MD_IDLE);
      busy_r      <= (state_next_s != MD_IDLE);
      out_valid_r <= (state_next_s == MD_DONE);
      if (load_result_s) begin
        out_value_r <= result_s;
        out_tag_r   <= result_tag_s;
      end
    end
  end

  // Operand latch on accept and the shift-add multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= OP_MUL;
      tag_r     <= {TAG_WIDTH{1'b0}};
      neg1_r    <= 1'b0;
      neg2_r    <= 1'b0;
      mcand_r   <= {PW{1'b0}};
      mplier_r  <= ZERO_X;
      acc_r     <= {PW{1'b0}};
      mul_cnt_r <= {MCW{1'b0}};
    end else if (accept_s) begin
      op_r      <= op_in_s;
      tag_r     <= in_tag;
      neg1_r    <= neg1_in_s;
      neg2_r    <= neg2_in_s;
      mcand_r   <= {ZERO_X, mag1_s};
      mplier_r  <= mag2_s;
      acc_r     <= {PW{1'b0}};
      mul_cnt_r <= MCW'(MUL_STEPS);
    end else if ((state_r == MD_MUL) && !flush) begin
      acc_r     <= acc_next_s;
      mcand_r   <= mcand_r << MUL_BITS;
      mplier_r  <= mplier_r >> MUL_BITS;
      mul_cnt_r <= mul_cnt_r - {{(MCW-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_value = out_value_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: arithmetic results, latencies, backpressure, flush and reset.
module tb_execute_md;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_opd1, in_opd2, out_value;
  logic [4:0]  in_tag, out_tag;

  int vectors = 0;
  int miscompares = 0;

  execute_md dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_opd1(in_opd1), .in_opd2(in_opd2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_funct3 = f; in_opd1 = a; in_opd2 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] t,
                     input logic [31:0] expv, input int explat);
    int lat;
    out_ready = 1'b1;
    issue(f, a, b, t);
    wait_result(lat);
    check({name, "_value"}, out_value, expv);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, t});
    check({name, "_latency"}, lat, explat);
    @(posedge clk); #1;
    check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'd0; in_opd1 = 32'd0; in_opd2 = 32'd0; in_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_value", out_value, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd4,  32'hFFFFFFEB, 9);
    run("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 9);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 9);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 9);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
    run("divu",   3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       33);
    run("remu",   3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        33);
    run("div0",   3'b100, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
    run("remu0",  3'b111, 32'd5,        32'd0,        5'd13, 32'd5,        1);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
    run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1);

    // Backpressure: result must hold while another op is offered.
    out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 5'd20);
    wait_result(lat);
    check("bp_first_value", out_value, 32'd14);
    in_funct3 = 3'b000; in_opd1 = 32'd2; in_opd2 = 32'd2; in_tag = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_value", out_value, 32'd14);
      check("bp_tag", {27'd0, out_tag}, 32'd20);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Flush on DIV cycle 12 cancels the op.
    issue(3'b100, 32'd1000, 32'd3, 5'd21);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush_no_valid", seen, 0);

    // A handshake coincident with flush is dropped.
    in_funct3 = 3'b000; in_opd1 = 32'd5; in_opd2 = 32'd5; in_tag = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_drop_busy", {31'd0, busy}, 32'd0);

    run("mul3x3", 3'b000, 32'd3, 32'd3, 5'd22, 32'd9, 9);

    // Reset in the middle of a multiply.
    issue(3'b000, 32'd12345, 32'd678, 5'd23);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_value", out_value, 32'd0);
    check("midrst_out_tag", {27'd0, out_tag}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Multi-cycle RV32M execute unit for the Qu out-of-order core. Sits beside the single-cycle integer execute stage and takes ops issued from the reservation stations.
- Performs MUL/MULH/MULHSU/MULHU iteratively (configurable bits per cycle) and DIV/DIVU/REM/REMU with a restoring divider.
- Returns results with their ROB tag over a valid/ready handshake toward the common data bus arbiter.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- MUL_BITS, 4, multiplier bits retired per cycle; must divide XLEN.
- TAG_WIDTH, 5, ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (mispredict/exception); cancels any op in flight
- in_valid  in  1  op offered
- in_ready  out  1  unit can accept an op
- in_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- in_opd1  in  XLEN  rs1 value
- in_opd2  in  XLEN  rs2 value
- in_tag  in  TAG_WIDTH  ROB tag
- out_valid  out  1  result available
- out_ready  in  1  CDB arbiter accepts result
- out_value  out  XLEN  result
- out_tag  out  TAG_WIDTH  tag of result
- busy  out  1  asserted in any state other than IDLE

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_value=0, out_tag=0, busy=0, FSM=IDLE. All internal accumulators are cleared.
- Input handshake: transfer when in_valid && in_ready. in_ready=1 only in IDLE, so there is one op in flight.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on accept:
  - Latch funct3, tag, and operands.
  - Form absolute values per signedness: MULH treats both operands as signed; MULHSU treats opd1 as signed only; DIV/REM treat both as signed.
  - Record the result sign.
  - MUL ops go to MUL. DIV ops go to DIV, unless they are special cases, which go straight to DONE.
- MUL:
  - Each cycle adds (multiplicand × next MUL_BITS multiplier bits) into a 2·XLEN accumulator, shifted appropriately.
  - After XLEN/MUL_BITS cycles, go to DONE.
  - Negate the 2·XLEN product when the result sign is negative.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV:
  - One quotient bit per cycle, restoring algorithm, XLEN cycles, then DONE.
  - Quotient sign is opd1 sign XOR opd2 sign; remainder sign is the opd1 sign.
  - Apply sign correction on the DONE transition.
- Special cases (resolved in IDLE, next state DONE, latency 1):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give opd1.
  - Signed overflow (opd1 = most negative value, opd2 = −1): DIV gives opd1; REM gives 0.
- DONE:
  - out_valid=1. out_value and out_tag stay stable until out_ready.
  - On out_ready, go to IDLE with out_valid=0 the next cycle.
- Latency from the accept edge to out_valid high:
  - MUL: XLEN/MUL_BITS + 1 cycles (9 at defaults).
  - DIV: XLEN + 1 cycles (33).
  - Special-case DIV: 1 cycle.
- out_ready held low: stay in DONE indefinitely; no new op is accepted.
- flush:
  - Has priority over everything except rst. Next state is IDLE and out_valid=0 the next cycle.
  - A handshake in the same cycle is ignored: the op is dropped.
  - A flush during DONE coincident with out_ready: the result is treated as not delivered.
- rst mid-operation: same as flush, plus out_value and out_tag are cleared.
- Arithmetic: accumulator is 2·XLEN bits with no overflow. Operand absolute value uses XLEN+1 bits, so the most negative value is handled correctly.

Decomposition:
- Package qu_common gains:
  - md_op_t: enum of the eight funct3 codes.
  - md_state_t: enum IDLE/MUL/DIV/DONE.
  - Helpers is_signed_opd1(md_op_t) and is_signed_opd2(md_op_t).
- One sub-module, md_div_core: iterative restoring divider (start, dividend, divisor, done, quotient, remainder; unsigned only).
- The multiplier stays inline in execute_md.

Test Plan:
- MUL 7 × −3 (tag 4), out_ready=1 → out_value 0xFFFFFFEB, tag 4, out_valid exactly 9 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1 × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 100 / 7 → 14, REMU → 2, each after 33 cycles.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5 after 1 cycle. DIV 0x80000000 / −1 → 0x80000000, REM → 0.
- Backpressure: out_ready low for 10 cycles → out_valid, value, and tag stay stable and in_ready=0; out_ready high → in_ready=1 on the next cycle.
- flush on DIV cycle 12 → out_valid never rises. A new MUL 3 × 3 accepted afterward → 9. rst during MUL → all outputs return to reset values the next cycle.
